// File: rtl/fila_pkg.sv
// Shared definitions for the fila queue and its command front-end.
package fila_pkg;

  localparam int FILA_MAX_LEN = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ENQ_PULSE = 3'd1,
    ENQ_WAIT  = 3'd2,
    DEQ_PULSE = 3'd3,
    DEQ_WAIT  = 3'd4
  } cmd_state_t;

endpackage

// File: rtl/fila_cmd_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle
// pulse on each debounced rising edge.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic clock_10KHz,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;

  // Level is accepted only after it differs from the stable value for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clock_10KHz) begin
    if (reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      press    <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press   <= 1'b0;
      if (sync2_r == stable_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_r <= sync2_r;
        cnt_r    <= {CW{1'b0}};
        press    <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fila_cmd.sv
// Command front-end for the fila queue: turns debounced button presses into
// single-cycle enqueue/dequeue commands and waits for the length to confirm.
module fila_cmd
  import fila_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int TIMEOUT_CYCLES  = 4,
  parameter int MAX_LEN         = FILA_MAX_LEN
) (
  input  logic       clock_10KHz,
  input  logic       reset,
  input  logic       btn_enq_in,
  input  logic       btn_deq_in,
  input  logic [7:0] switches_in,
  input  logic [7:0] len_in,
  input  logic [7:0] data_in,
  output logic       enqueue_out,
  output logic       dequeue_out,
  output logic [7:0] data_out,
  output logic [7:0] last_deq_out,
  output logic       busy_out,
  output logic       error_out
);

  logic       enq_press_s;
  logic       deq_press_s;
  cmd_state_t state_r;
  logic [7:0] snap_r;
  logic [7:0] wait_cnt_r;
  logic [7:0] deq_hold_r;
  logic       deq_capt_r;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enq (
    .clock_10KHz (clock_10KHz),
    .reset       (reset),
    .btn         (btn_enq_in),
    .press       (enq_press_s)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_deq (
    .clock_10KHz (clock_10KHz),
    .reset       (reset),
    .btn         (btn_deq_in),
    .press       (deq_press_s)
  );

  // Command FSM; every output is a register so the queue sees glitch-free commands
  always_ff @(posedge clock_10KHz) begin
    if (reset) begin
      state_r      <= IDLE;
      snap_r       <= 8'd0;
      wait_cnt_r   <= 8'd0;
      deq_hold_r   <= 8'd0;
      deq_capt_r   <= 1'b0;
      enqueue_out  <= 1'b0;
      dequeue_out  <= 1'b0;
      data_out     <= 8'd0;
      last_deq_out <= 8'd0;
      busy_out     <= 1'b0;
      error_out    <= 1'b0;
    end else begin
      enqueue_out <= 1'b0;
      dequeue_out <= 1'b0;
      error_out   <= 1'b0;
      deq_capt_r  <= 1'b0;
      if (deq_capt_r) begin
        last_deq_out <= deq_hold_r;
      end
      case (state_r)
        IDLE: begin
          // enqueue has priority; a coincident dequeue press is discarded
          if (enq_press_s) begin
            if (len_in < 8'(MAX_LEN)) begin
              data_out    <= switches_in;
              snap_r      <= len_in;
              enqueue_out <= 1'b1;
              busy_out    <= 1'b1;
              state_r     <= ENQ_PULSE;
            end else begin
              error_out <= 1'b1;
            end
          end else if (deq_press_s) begin
            if (len_in != 8'd0) begin
              snap_r      <= len_in;
              dequeue_out <= 1'b1;
              busy_out    <= 1'b1;
              state_r     <= DEQ_PULSE;
            end else begin
              error_out <= 1'b1;
            end
          end
        end
        ENQ_PULSE: begin
          wait_cnt_r <= 8'd0;
          state_r    <= ENQ_WAIT;
        end
        DEQ_PULSE: begin
          wait_cnt_r <= 8'd0;
          state_r    <= DEQ_WAIT;
        end
        ENQ_WAIT: begin
          if (len_in == snap_r + 8'd1) begin
            busy_out <= 1'b0;
            state_r  <= IDLE;
          end else if (wait_cnt_r == 8'(TIMEOUT_CYCLES - 1)) begin
            error_out <= 1'b1;
            busy_out  <= 1'b0;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        DEQ_WAIT: begin
          // queue output is only valid in the cycle the length drops
          if (len_in == snap_r - 8'd1) begin
            deq_hold_r <= data_in;
            deq_capt_r <= 1'b1;
            busy_out   <= 1'b0;
            state_r    <= IDLE;
          end else if (wait_cnt_r == 8'(TIMEOUT_CYCLES - 1)) begin
            error_out <= 1'b1;
            busy_out  <= 1'b0;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        default: begin
          busy_out <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fila_cmd.sv
// Scoreboard bench for fila_cmd driving a behavioural fila queue model.
module tb_fila_cmd;

  localparam int DB = 100;
  localparam logic [2:0] K_ENQ = 3'b100;
  localparam logic [2:0] K_DEQ = 3'b010;
  localparam logic [2:0] K_ERR = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clock_10KHz = 1'b0;
  logic       reset;
  logic       btn_enq_in;
  logic       btn_deq_in;
  logic [7:0] switches_in;
  logic [7:0] len_in;
  logic [7:0] data_in;
  logic       enqueue_out;
  logic       dequeue_out;
  logic [7:0] data_out;
  logic [7:0] last_deq_out;
  logic       busy_out;
  logic       error_out;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt = 0;
  exp_t exp_q[$];

  int         exp_len = 0;
  logic [7:0] exp_fifo[$];
  logic [7:0] exp_last = 8'd0;

  // fila model state
  logic [7:0] mq[$];
  logic [7:0] len_m;
  logic [7:0] dout_m;
  logic       enq_d;
  logic       deq_d;
  logic       freeze = 1'b0;

  fila_cmd dut (
    .clock_10KHz  (clock_10KHz),
    .reset        (reset),
    .btn_enq_in   (btn_enq_in),
    .btn_deq_in   (btn_deq_in),
    .switches_in  (switches_in),
    .len_in       (len_in),
    .data_in      (data_in),
    .enqueue_out  (enqueue_out),
    .dequeue_out  (dequeue_out),
    .data_out     (data_out),
    .last_deq_out (last_deq_out),
    .busy_out     (busy_out),
    .error_out    (error_out)
  );

  always #5 clock_10KHz = ~clock_10KHz;

  assign len_in  = len_m;
  assign data_in = dout_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue model: samples the command one cycle late, so length moves two cycles after it
  always @(posedge clock_10KHz) begin
    if (reset) begin
      mq.delete();
      len_m  <= 8'd0;
      dout_m <= 8'd0;
      enq_d  <= 1'b0;
      deq_d  <= 1'b0;
    end else begin
      enq_d <= enqueue_out && !freeze;
      deq_d <= dequeue_out && !freeze;
      if (enq_d && mq.size() < 8) begin
        mq.push_back(data_out);
        len_m <= len_m + 8'd1;
      end
      if (deq_d && mq.size() > 0) begin
        dout_m <= mq[0];
        void'(mq.pop_front());
        len_m <= len_m - 8'd1;
      end
    end
  end

  // Scoreboard monitor: every high cycle of a command/error output consumes one expectation
  always @(negedge clock_10KHz) begin
    exp_t e;
    if (reset !== 1'b1) begin
      if (enqueue_out || dequeue_out || error_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_evt", {29'd0, enqueue_out, dequeue_out, error_out}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("evt_kind", {29'd0, enqueue_out, dequeue_out, error_out}, {29'd0, e.kind});
          if (e.kind == K_ENQ) check("enq_data", {24'd0, data_out}, {24'd0, e.data});
        end
      end
      if (busy_out) busy_cnt++;
    end
  end

  task automatic push_exp(input logic [2:0] kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic hold_release();
    int n;
    repeat (DB + 8) @(negedge clock_10KHz);
    n = 0;
    while (busy_out && n < 40) begin
      @(negedge clock_10KHz);
      n++;
    end
    check("busy_release", {31'd0, busy_out}, 32'd0);
    btn_enq_in = 1'b0;
    btn_deq_in = 1'b0;
    repeat (DB + 8) @(negedge clock_10KHz);
  endtask

  task automatic do_reset();
    check("sb_drained", exp_q.size(), 32'd0);
    @(negedge clock_10KHz);
    reset = 1'b1;
    btn_enq_in = 1'b0;
    btn_deq_in = 1'b0;
    repeat (3) @(negedge clock_10KHz);
    reset = 1'b0;
    exp_q.delete();
    exp_fifo.delete();
    exp_len  = 0;
    exp_last = 8'd0;
  endtask

  task automatic press_enq(input logic [7:0] sw);
    int eb;
    if (exp_len >= 8) begin
      push_exp(K_ERR, 8'd0);
      eb = 0;
    end else begin
      push_exp(K_ENQ, sw);
      exp_fifo.push_back(sw);
      exp_len++;
      eb = 3;
    end
    @(negedge clock_10KHz);
    busy_cnt = 0;
    switches_in = sw;
    btn_enq_in = 1'b1;
    hold_release();
    check("len_after_enq", {24'd0, len_in}, exp_len);
    check("busy_cycles_enq", busy_cnt, eb);
  endtask

  task automatic press_deq();
    int eb;
    if (exp_len == 0) begin
      push_exp(K_ERR, 8'd0);
      eb = 0;
    end else begin
      push_exp(K_DEQ, 8'd0);
      exp_last = exp_fifo.pop_front();
      exp_len--;
      eb = 3;
    end
    @(negedge clock_10KHz);
    busy_cnt = 0;
    btn_deq_in = 1'b1;
    hold_release();
    check("len_after_deq", {24'd0, len_in}, exp_len);
    check("last_deq", {24'd0, last_deq_out}, {24'd0, exp_last});
    check("busy_cycles_deq", busy_cnt, eb);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    btn_enq_in = 1'b0;
    btn_deq_in = 1'b0;
    switches_in = 8'd0;
    repeat (4) @(negedge clock_10KHz);
    check("rst_outputs", {enqueue_out, dequeue_out, data_out, last_deq_out, busy_out, error_out}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock_10KHz);

    // 1: bouncing enqueue button yields one command
    switches_in = 8'h5A;
    push_exp(K_ENQ, 8'h5A);
    exp_fifo.push_back(8'h5A);
    exp_len = 1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      btn_enq_in = ~btn_enq_in;
      @(negedge clock_10KHz);
    end
    btn_enq_in = 1'b1;
    hold_release();
    check("t1_len", {24'd0, len_in}, 32'd1);
    check("t1_data_out", {24'd0, data_out}, 32'h5A);
    check("t1_busy", busy_cnt, 32'd3);

    // 2: four enqueues then two dequeues
    do_reset();
    press_enq(8'h11);
    press_enq(8'h22);
    press_enq(8'h33);
    press_enq(8'h44);
    press_deq();
    check("t2_first_deq", {24'd0, last_deq_out}, 32'h11);
    press_deq();
    check("t2_second_deq", {24'd0, last_deq_out}, 32'h22);
    check("t2_len", {24'd0, len_in}, 32'd2);
    check("t2_data_hold", {24'd0, data_out}, 32'h44);

    // 4: simultaneous presses at len 3, then a dequeue press landing while busy
    press_enq(8'h55);
    @(negedge clock_10KHz);
    busy_cnt = 0;
    push_exp(K_ENQ, 8'h66);
    exp_fifo.push_back(8'h66);
    exp_len++;
    switches_in = 8'h66;
    btn_enq_in = 1'b1;
    btn_deq_in = 1'b1;
    hold_release();
    check("t4_len_both", {24'd0, len_in}, 32'd4);
    check("t4_busy_both", busy_cnt, 32'd3);
    @(negedge clock_10KHz);
    busy_cnt = 0;
    push_exp(K_ENQ, 8'h77);
    exp_fifo.push_back(8'h77);
    exp_len++;
    switches_in = 8'h77;
    btn_enq_in = 1'b1;
    repeat (2) @(negedge clock_10KHz);
    btn_deq_in = 1'b1;
    hold_release();
    check("t4_len_skew", {24'd0, len_in}, 32'd5);
    check("t4_last_deq_kept", {24'd0, last_deq_out}, 32'h22);

    // 3: full queue rejects enqueue, empty queue rejects dequeue
    do_reset();
    for (int i = 0; i < 8; i++) press_enq(8'(8'hA0 + i));
    check("t3_full", {24'd0, len_in}, 32'd8);
    press_enq(8'hEE);
    check("t3_data_kept", {24'd0, data_out}, 32'hA7);
    do_reset();
    press_deq();

    // 5: queue never confirms -> timeout error after four wait cycles
    do_reset();
    freeze = 1'b1;
    push_exp(K_ENQ, 8'hC3);
    push_exp(K_ERR, 8'd0);
    @(negedge clock_10KHz);
    busy_cnt = 0;
    switches_in = 8'hC3;
    btn_enq_in = 1'b1;
    hold_release();
    check("t5_busy", busy_cnt, 32'd5);
    check("t5_len", {24'd0, len_in}, 32'd0);
    freeze = 1'b0;

    // 6: reset during DEQ_WAIT aborts cleanly
    do_reset();
    press_enq(8'h99);
    press_enq(8'hAB);
    push_exp(K_DEQ, 8'd0);
    @(negedge clock_10KHz);
    btn_deq_in = 1'b1;
    n = 0;
    while (!dequeue_out && n < DB + 40) begin
      @(negedge clock_10KHz);
      n++;
    end
    check("t6_deq_seen", {31'd0, dequeue_out}, 32'd1);
    btn_deq_in = 1'b0;
    @(negedge clock_10KHz);
    reset = 1'b1;
    @(negedge clock_10KHz);
    check("t6_rst_outputs", {enqueue_out, dequeue_out, data_out, last_deq_out, busy_out, error_out}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_fifo.delete();
    exp_len  = 0;
    exp_last = 8'd0;
    repeat (DB + 20) @(negedge clock_10KHz);
    check("t6_idle_after", {30'd0, busy_out, dequeue_out}, 32'd0);
    press_enq(8'h3C);
    press_deq();
    check("t6_deq_byte", {24'd0, last_deq_out}, 32'h3C);

    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
